// File: rtl/eth_clk_pkg.sv
// Shared types and defaults for the Ethernet TX clock/reset generator.
// Holds the speed and state enums, the default half-periods, and the
// helper functions used to size counters and to legalise a requested speed.
package eth_clk_pkg;

    typedef enum logic [1:0] {
        e_10m   = 2'b00,
        e_100m  = 2'b01,
        e_1000m = 2'b10
    } eth_speed_e;

    typedef enum logic [1:0] {
        e_hold,
        e_run,
        e_drain
    } eth_clk_state_e;

    localparam int unsigned GTX_HALF_DEF     = 1;
    localparam int unsigned TX_HALF_1000_DEF = 1;
    localparam int unsigned TX_HALF_100_DEF  = 5;
    localparam int unsigned TX_HALF_10_DEF   = 50;
    localparam int unsigned RST_HOLD_DEF     = 128;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // The reserved code 2'b11 is treated as 1000M.
    function automatic eth_speed_e map_speed(input logic [1:0] s);
        return (s == 2'b11) ? e_1000m : eth_speed_e'(s);
    endfunction

endpackage

// File: rtl/eth_tx_clk_rst_gen_if.sv
// Control/status bundle of the TX clock/reset generator.
//   speed_i      requested speed (00=10M, 01=100M, 10=1000M, 11=reserved)
//   speed_r_o    speed currently applied to the clocks
//   tx_clk_r_o   PHY RGMII TX clock
//   gtx_clk_r_o  GTX clock
//   gtx_rst_r_o  GTX-domain reset, active high
//   ready_r_o    clocks valid at speed_r_o
// master: the consumer that requests a speed; slave: the generator.
interface eth_tx_clk_rst_gen_if;
    import eth_clk_pkg::*;

    logic [1:0] speed_i;
    eth_speed_e speed_r_o;
    logic       tx_clk_r_o;
    logic       gtx_clk_r_o;
    logic       gtx_rst_r_o;
    logic       ready_r_o;

    modport master (
        output speed_i,
        input  speed_r_o, tx_clk_r_o, gtx_clk_r_o, gtx_rst_r_o, ready_r_o
    );

    modport slave (
        input  speed_i,
        output speed_r_o, tx_clk_r_o, gtx_clk_r_o, gtx_rst_r_o, ready_r_o
    );
endinterface

// File: rtl/eth_clk_divider.sv
// Registered toggle divider.
//   clk_i   fast clock
//   i_clr   synchronous clear: counter and output clock to 0 (wins over i_en)
//   i_en    advance the phase counter
//   i_last  half-period minus one, selectable at runtime
//   o_clk   divided clock (flop output)
//   o_next  value o_clk takes at the next edge if not cleared
module eth_clk_divider #(
    parameter int unsigned width_p = 1
) (
    input  logic               clk_i,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [width_p-1:0] i_last,
    output logic               o_clk,
    output logic               o_next
);

    logic [width_p-1:0] r_cnt;
    logic               r_clk;
    logic               w_wrap;

    assign w_wrap = i_en && (r_cnt == i_last);

    // Clear is deliberately left out so the parent can use o_next to decide
    // when to clear without forming a combinational loop.
    assign o_next = w_wrap ? ~r_clk : r_clk;
    assign o_clk  = r_clk;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (i_clr) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + width_p'(1);
            r_clk <= o_next;
        end
    end

endmodule

// File: rtl/eth_tx_clk_rst_gen.sv
// Multi-speed GTX / RGMII TX clock and GTX reset generator.
//   clk_i    fast clock (250 MHz nominal)
//   reset_i  synchronous, active-high reset
//   bus      slave side of eth_tx_clk_rst_gen_if (speed request, clocks,
//            GTX reset, ready)
// A speed change drains both clocks to a common low phase, re-holds the GTX
// reset, then restarts both clocks phase-aligned at the new speed.
module eth_tx_clk_rst_gen
    import eth_clk_pkg::*;
#(
    parameter int unsigned gtx_half_p     = GTX_HALF_DEF,
    parameter int unsigned tx_half_1000_p = TX_HALF_1000_DEF,
    parameter int unsigned tx_half_100_p  = TX_HALF_100_DEF,
    parameter int unsigned tx_half_10_p   = TX_HALF_10_DEF,
    parameter int unsigned rst_hold_p     = RST_HOLD_DEF
) (
    input logic                 clk_i,
    input logic                 reset_i,
    eth_tx_clk_rst_gen_if.slave bus
);

    localparam int unsigned tx_max_lp =
        (tx_half_10_p > tx_half_100_p)
            ? ((tx_half_10_p > tx_half_1000_p) ? tx_half_10_p : tx_half_1000_p)
            : ((tx_half_100_p > tx_half_1000_p) ? tx_half_100_p : tx_half_1000_p);
    localparam int unsigned tx_w_lp   = safe_clog2(tx_max_lp);
    localparam int unsigned gtx_w_lp  = safe_clog2(gtx_half_p);
    localparam int unsigned hold_w_lp = safe_clog2(rst_hold_p + 1);

    // Integer ratios guarantee the two clocks share falling edges, which
    // bounds DRAIN to two TX half-periods.
    if ((tx_half_1000_p % gtx_half_p) != 0 || (tx_half_100_p % gtx_half_p) != 0 ||
        (tx_half_10_p % gtx_half_p) != 0) begin : g_bad_ratio
        $error("eth_tx_clk_rst_gen: every tx_half_* must be a multiple of gtx_half_p");
    end
    if (rst_hold_p < 2 * tx_half_10_p) begin : g_bad_hold
        $error("eth_tx_clk_rst_gen: rst_hold_p must be >= 2*tx_half_10_p");
    end

    eth_clk_state_e         r_state, w_state_next;
    logic [hold_w_lp-1:0]   r_hold_cnt, w_hold_cnt_next;
    eth_speed_e             r_speed, w_speed_next;
    eth_speed_e             r_pend, w_pend_next;
    logic                   r_gtx_rst, w_gtx_rst_next;
    logic                   r_ready, w_ready_next;

    logic [tx_w_lp-1:0]     w_tx_last;
    logic                   w_tx_clk, w_tx_next;
    logic                   w_gtx_clk, w_gtx_next;
    logic                   w_div_clr, w_div_en, w_drain_done;

    always_comb begin
        case (r_speed)
            e_10m:   w_tx_last = tx_w_lp'(tx_half_10_p - 1);
            e_100m:  w_tx_last = tx_w_lp'(tx_half_100_p - 1);
            default: w_tx_last = tx_w_lp'(tx_half_1000_p - 1);
        endcase
    end

    // Both clocks will be low after this edge: the only safe place to stop.
    assign w_drain_done = (r_state == e_drain) && !w_tx_next && !w_gtx_next;
    // Clearing through the whole of HOLD leaves the phase counters at 0 on
    // RUN entry, which is what aligns the two clocks.
    assign w_div_clr    = reset_i || (r_state == e_hold) || w_drain_done;
    assign w_div_en     = (r_state != e_hold);

    eth_clk_divider #(.width_p(tx_w_lp)) u_tx_div (
        .clk_i  (clk_i),
        .i_clr  (w_div_clr),
        .i_en   (w_div_en),
        .i_last (w_tx_last),
        .o_clk  (w_tx_clk),
        .o_next (w_tx_next)
    );

    eth_clk_divider #(.width_p(gtx_w_lp)) u_gtx_div (
        .clk_i  (clk_i),
        .i_clr  (w_div_clr),
        .i_en   (w_div_en),
        .i_last (gtx_w_lp'(gtx_half_p - 1)),
        .o_clk  (w_gtx_clk),
        .o_next (w_gtx_next)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        w_speed_next    = r_speed;
        w_pend_next     = r_pend;
        w_gtx_rst_next  = r_gtx_rst;
        w_ready_next    = r_ready;
        unique case (r_state)
            e_hold: begin
                w_hold_cnt_next = r_hold_cnt + hold_w_lp'(1);
                if (r_hold_cnt == hold_w_lp'(rst_hold_p - 1)) begin
                    w_state_next   = e_run;
                    w_gtx_rst_next = 1'b0;
                    w_ready_next   = 1'b1;
                end
            end
            e_run: begin
                if (bus.speed_i != r_speed && bus.speed_i != 2'b11) begin
                    w_state_next = e_drain;
                    w_pend_next  = eth_speed_e'(bus.speed_i);
                    w_ready_next = 1'b0;
                end
            end
            e_drain: begin
                if (w_drain_done) begin
                    w_state_next    = e_hold;
                    w_speed_next    = r_pend;
                    w_gtx_rst_next  = 1'b1;
                    w_hold_cnt_next = '0;
                end
            end
            default: w_state_next = e_hold;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= e_hold;
            r_hold_cnt <= '0;
            r_speed    <= map_speed(bus.speed_i);
            r_pend     <= map_speed(bus.speed_i);
            r_gtx_rst  <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_speed    <= w_speed_next;
            r_pend     <= w_pend_next;
            r_gtx_rst  <= w_gtx_rst_next;
            r_ready    <= w_ready_next;
        end
    end

    assign bus.speed_r_o   = r_speed;
    assign bus.tx_clk_r_o  = w_tx_clk;
    assign bus.gtx_clk_r_o = w_gtx_clk;
    assign bus.gtx_rst_r_o = r_gtx_rst;
    assign bus.ready_r_o   = r_ready;

endmodule
